// File: rtl/memb_pkg.sv
// Shared types and helpers for the skewed B-matrix feeder.
package memb_pkg;

    localparam int unsigned ROW_DIM  = 8;
    localparam int unsigned ROW_BITS = 8;

    typedef logic signed [ROW_BITS-1:0] row_t [ROW_DIM];

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } feed_state_t;

    // Register count for a lane: lane i waits i extra cycles when skewing.
    function automatic int unsigned skew_depth(input int unsigned lane, input bit skew_en);
        return skew_en ? lane + 32'd1 : 32'd1;
    endfunction

endpackage

// File: rtl/memb_lane_delay.sv
// Per-lane data+valid shift register with a shared advance enable.
module memb_lane_delay #(
    parameter int unsigned W      = 8,
    parameter int unsigned STAGES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] din,
    input  logic                vin,
    output logic signed [W-1:0] dout,
    output logic                vout,
    output logic                inflight_c
);

    logic signed [W-1:0] data_q [STAGES];
    logic [STAGES-1:0]   valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(STAGES); s++) begin
                data_q[s]  <= '0;
                valid_q[s] <= 1'b0;
            end
        end else if (en) begin
            data_q[0]  <= din;
            valid_q[0] <= vin;
            for (int s = 1; s < int'(STAGES); s++) begin
                data_q[s]  <= data_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign dout = data_q[STAGES-1];
    assign vout = valid_q[STAGES-1];

    // Valids that will still be inside the lane after the next advance.
    generate
        if (STAGES > 1) begin : g_inflight
            assign inflight_c = |valid_q[STAGES-2:0];
        end else begin : g_no_inflight
            assign inflight_c = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/memb_skew_feeder.sv
// Row FIFO feeding the systolic array's B side with per-lane diagonal skew and drain tracking.
module memb_skew_feeder
    import memb_pkg::*;
#(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned DIM     = 8,
    parameter int unsigned DEPTH   = 8,
    parameter bit          SKEW_EN = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic signed [BITS_AB-1:0]        Bin [DIM],
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    input  logic                             en,
    output logic signed [BITS_AB-1:0]        Bout [DIM],
    output logic [DIM-1:0]                   Bvalid,
    output logic                             busy,
    output logic                             done
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic signed [BITS_AB-1:0] mem [DEPTH][DIM];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count_next;
    logic                      push_c;
    logic                      pop_c;
    logic                      valid_after_c;
    logic [DIM-1:0]            inflight_c;
    logic signed [BITS_AB-1:0] lane_din [DIM];
    feed_state_t               state;
    feed_state_t               state_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_c = wr_en && !full;
    assign pop_c  = en && !empty;

    always_comb begin
        count_next = count;
        case ({push_c, pop_c})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // FIFO bookkeeping; flags registered from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_c)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= Bin;
    end

    // Popped row enters stage 0; an empty FIFO injects a zero bubble.
    always_comb begin
        for (int l = 0; l < int'(DIM); l++) begin
            lane_din[l] = pop_c ? mem[rd_ptr][l] : '0;
        end
    end

    generate
        for (genvar l = 0; l < int'(DIM); l++) begin : g_lane
            memb_lane_delay #(
                .W      (BITS_AB),
                .STAGES (skew_depth(l, SKEW_EN))
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .en         (en),
                .din        (lane_din[l]),
                .vin        (pop_c),
                .dout       (Bout[l]),
                .vout       (Bvalid[l]),
                .inflight_c (inflight_c[l])
            );
        end
    endgenerate

    assign valid_after_c = pop_c || (|inflight_c);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (!empty) state_next = (en && count_next == '0) ? DRAIN : STREAM;
            end
            STREAM: begin
                if (en && count_next == '0) state_next = DRAIN;
            end
            DRAIN: begin
                if (en) begin
                    if (count_next != '0)    state_next = STREAM;
                    else if (!valid_after_c) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == DRAIN) && (state_next == IDLE);
        end
    end

endmodule

// File: tb/tb_memb_skew_feeder.sv
// Randomised scoreboard bench for memb_skew_feeder plus an unskewed instance check.
module tb_memb_skew_feeder;

    localparam int DIM   = 8;
    localparam int BW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, wr_en, en;
    logic signed [BW-1:0] Bin [DIM];
    logic                 full, empty, busy, done;
    logic [CW-1:0]        count;
    logic signed [BW-1:0] Bout [DIM];
    logic [DIM-1:0]       Bvalid;

    logic                 wr2, en2;
    logic signed [BW-1:0] Bin2 [DIM];
    logic                 full2, empty2, busy2, done2;
    logic [CW-1:0]        count2;
    logic signed [BW-1:0] Bout2 [DIM];
    logic [DIM-1:0]       Bvalid2;

    memb_skew_feeder #(.BITS_AB(BW), .DIM(DIM), .DEPTH(DEPTH), .SKEW_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .Bin(Bin), .full(full), .empty(empty),
        .count(count), .en(en), .Bout(Bout), .Bvalid(Bvalid), .busy(busy), .done(done)
    );

    memb_skew_feeder #(.BITS_AB(BW), .DIM(DIM), .DEPTH(DEPTH), .SKEW_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr2), .Bin(Bin2), .full(full2), .empty(empty2),
        .count(count2), .en(en2), .Bout(Bout2), .Bvalid(Bvalid2), .busy(busy2), .done(done2)
    );

    // Reference model: row queue, history of the last DIM advances, per-lane expectations.
    bit [DIM*BW-1:0] fifo_m [$];
    bit              hist_v [DIM];
    bit [BW-1:0]     exp_q  [DIM][$];
    bit [BW-1:0]     held   [DIM];
    bit              busy_m, done_m, last_adv;
    bit [DIM*BW-1:0] cur_row;
    bit              mon_on, resid_req;
    int              t6_step;
    int              checks, failures;

    task automatic model_edge();
        bit              pop, any;
        bit              was_busy;
        int              cnt_before;
        bit [DIM*BW-1:0] r;
        if (rst) begin
            fifo_m.delete();
            for (int i = 0; i < DIM; i++) begin
                hist_v[i] = 1'b0;
                exp_q[i].delete();
            end
            busy_m = 1'b0; done_m = 1'b0; last_adv = 1'b0;
            return;
        end
        done_m     = 1'b0;
        was_busy   = busy_m;
        cnt_before = fifo_m.size();
        pop        = en && (cnt_before > 0);
        if (pop) begin
            r = fifo_m.pop_front();
            for (int i = 0; i < DIM; i++) exp_q[i].push_back(r[i*BW +: BW]);
        end
        if (wr_en && cnt_before < DEPTH) fifo_m.push_back(cur_row);
        if (en) begin
            for (int j = DIM - 1; j > 0; j--) hist_v[j] = hist_v[j-1];
            hist_v[0] = pop;
        end
        last_adv = en;
        any = 1'b0;
        for (int j = 0; j < DIM; j++) any |= hist_v[j];
        if (!was_busy) begin
            if (cnt_before > 0) busy_m = 1'b1;
        end else if (en && fifo_m.size() == 0 && !any) begin
            busy_m = 1'b0;
            done_m = 1'b1;
        end
    endtask

    task automatic cycle(input bit r, input bit w, input bit e, input bit [DIM*BW-1:0] row);
        rst = r; wr_en = w; en = e; cur_row = row;
        for (int i = 0; i < DIM; i++) Bin[i] = row[i*BW +: BW];
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic bit [DIM*BW-1:0] bcast(input bit [BW-1:0] v);
        bit [DIM*BW-1:0] r;
        for (int i = 0; i < DIM; i++) r[i*BW +: BW] = v;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares every visible output against the model on the falling edge.
    always @(negedge clk) begin
        bit [BW-1:0] d;
        if (mon_on) begin
            chk("count", int'(count), fifo_m.size());
            chk("full",  int'(full),  int'(fifo_m.size() == DEPTH));
            chk("empty", int'(empty), int'(fifo_m.size() == 0));
            chk("busy",  int'(busy),  int'(busy_m));
            chk("done",  int'(done),  int'(done_m));
            for (int i = 0; i < DIM; i++) begin
                d = Bout[i];
                chk("bvalid", int'(Bvalid[i]), int'(hist_v[i]));
                if (Bvalid[i] && last_adv) begin
                    if (exp_q[i].size() == 0) chk("lane_underflow", 1, 0);
                    else begin
                        held[i] = exp_q[i].pop_front();
                        chk("bout", int'(d), int'(held[i]));
                    end
                end else if (Bvalid[i]) begin
                    chk("bout_hold", int'(d), int'(held[i]));
                end else begin
                    chk("bout_bubble", int'(d), 0);
                end
            end
        end
        if (resid_req) begin
            for (int i = 0; i < DIM; i++) chk("lane_residual", exp_q[i].size(), 0);
        end
        case (t6_step)
            1: begin
                chk("t6_count", int'(count2), 1);
                chk("t6_busy_pre", int'(busy2), 0);
            end
            2: begin
                for (int i = 0; i < DIM; i++) chk("t6_bout", int'(Bout2[i]), -i);
                chk("t6_bvalid", int'(Bvalid2), 255);
                chk("t6_count0", int'(count2), 0);
                chk("t6_busy", int'(busy2), 1);
            end
            3: begin
                chk("t6_bvalid_clear", int'(Bvalid2), 0);
                chk("t6_done", int'(done2), 1);
                chk("t6_busy_end", int'(busy2), 0);
            end
            4: chk("t6_done_once", int'(done2), 0);
            default: ;
        endcase
    end

    task automatic idle_cycles(input int n, input bit e);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, e, '0);
    endtask

    initial begin
        bit [DIM*BW-1:0] row;
        checks = 0; failures = 0; mon_on = 1'b0; resid_req = 1'b0; t6_step = 0;
        wr2 = 1'b0; en2 = 1'b0;
        for (int i = 0; i < DIM; i++) Bin2[i] = '0;
        for (int i = 0; i < DIM; i++) held[i] = '0;
        cycle(1'b1, 1'b0, 1'b0, '0);
        mon_on = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, '0);
        idle_cycles(2, 1'b0);

        // Single row, lanes emerge diagonally
        for (int i = 0; i < DIM; i++) row[i*BW +: BW] = BW'(i + 1);
        cycle(1'b0, 1'b1, 1'b0, row);
        idle_cycles(14, 1'b1);

        // Overfill while frozen, then stream back-to-back
        for (int k = 1; k <= 5; k++) cycle(1'b0, 1'b1, 1'b0, bcast(BW'(k * 16)));
        idle_cycles(16, 1'b1);

        // Mid-stream freeze
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, bcast(BW'(8'hA0 + k)));
        idle_cycles(2, 1'b1);
        idle_cycles(3, 1'b0);
        idle_cycles(14, 1'b1);

        // Write refused when full while popping; bubble at empty
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, bcast(BW'(8'hC0 + k)));
        cycle(1'b0, 1'b1, 1'b1, bcast(8'hEE));
        idle_cycles(16, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, bcast(8'h77));
        idle_cycles(14, 1'b1);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            row = {$urandom, $urandom};
            cycle(1'b0, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 70, row);
        end
        idle_cycles(DEPTH + DIM + 4, 1'b1);
        resid_req = 1'b1;
        idle_cycles(1, 1'b0);
        resid_req = 1'b0;

        // Reset with rows in flight
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, bcast(BW'(8'h31 + k)));
        idle_cycles(2, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, '0);
        idle_cycles(3, 1'b1);

        // Unskewed instance: all lanes aligned one edge after the pop
        wr2 = 1'b1;
        for (int i = 0; i < DIM; i++) Bin2[i] = BW'(-i);
        idle_cycles(1, 1'b0);
        wr2 = 1'b0; t6_step = 1;
        idle_cycles(1, 1'b0);
        en2 = 1'b1; t6_step = 0;
        idle_cycles(1, 1'b0);
        t6_step = 2;
        idle_cycles(1, 1'b0);
        t6_step = 3;
        idle_cycles(1, 1'b0);
        t6_step = 4;
        idle_cycles(1, 1'b0);
        t6_step = 0; en2 = 1'b0;
        idle_cycles(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
